// File: rtl/trng_sampler.sv
// Samples the ring-oscillator entropy bit, debiases it with a von Neumann extractor,
// packs the result into words behind a valid/ready holding register and health-tests the raw stream.
//
// state  | meaning
// FIRST  | waiting for the first sample of a pair
// SECOND | first sample latched, next strobe decides whether a bit is emitted
module trng_sampler #(
    parameter int WORD_WIDTH = 8,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  raw_bit,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  health_fail,
    output logic [7:0]            drop_count
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(WORD_WIDTH);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    typedef enum logic {FIRST, SECOND} pair_state_t;

    logic [1:0]            sync_q;
    logic                  sbit;
    logic [DIV_W-1:0]      div_cnt;
    pair_state_t           pair_state;
    logic                  first_bit;
    logic [WORD_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [REP_W-1:0]      rep_cnt;
    logic [REP_W-1:0]      rep_next;
    logic                  prev_bit;

    logic                  strobe;
    logic                  emit;
    logic                  word_done;
    logic [WORD_WIDTH-1:0] word_next;
    logic                  accept;
    logic                  load;
    logic                  drop;

    assign sbit      = sync_q[1];
    assign strobe    = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign emit      = strobe && (pair_state == SECOND) && (sbit != first_bit);
    assign word_done = emit && (bit_cnt == CNT_W'(WORD_WIDTH - 1));
    assign word_next = {shreg[WORD_WIDTH-2:0], first_bit};

    // Completed words are ignored entirely once the source is deemed unhealthy.
    assign accept = word_done && !health_fail;
    assign load   = accept && (!data_valid || data_ready);
    assign drop   = accept && data_valid && !data_ready;

    always_comb begin
        rep_next = rep_cnt;
        if (sbit != prev_bit) begin
            rep_next = REP_W'(1);
        end else if (rep_cnt != REP_W'(REP_LIMIT)) begin
            rep_next = rep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || div_cnt == DIV_W'(SAMPLE_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_state <= FIRST;
            first_bit  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
        end else if (!enable) begin
            pair_state <= FIRST;
        end else if (strobe) begin
            case (pair_state)
                FIRST: begin
                    first_bit  <= sbit;
                    pair_state <= SECOND;
                end
                SECOND: begin
                    pair_state <= FIRST;
                    if (emit) begin
                        shreg   <= word_next;
                        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: pair_state <= FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt     <= '0;
            prev_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (strobe) begin
            rep_cnt  <= rep_next;
            prev_bit <= sbit;
            if (rep_next == REP_W'(REP_LIMIT)) begin
                health_fail <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            drop_count <= '0;
        end else begin
            if (load) begin
                data_out   <= word_next;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/trng_sampler.md
Name: trng_sampler

Overview:
Downstream consumer of the ring-oscillator XOR combiner output. Synchronises the asynchronous raw entropy bit into the system clock domain and samples it at a programmable rate. Removes bias with a von Neumann extractor, packs the debiased bits into words and presents them on a valid/ready interface. Also runs a repetition-count health test on the raw samples.

Parameters:
WORD_WIDTH, 8, bits per output word (at least 2)
SAMPLE_DIV, 4, clock cycles per raw sample (at least 1)
REP_LIMIT, 32, consecutive identical raw samples that trip the health test (at least 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  sampling enable
raw_bit  input  1  asynchronous raw entropy bit from the RO combiner
data_out  output  WORD_WIDTH  debiased word
data_valid  output  1  data_out holds a word
data_ready  input  1  consumer accepts the word
health_fail  output  1  sticky repetition-count failure
drop_count  output  8  words dropped because the holding register was full (saturates at 255)

Behaviour:
- Reset is asynchronous and active-low: one clock (clk), and rst_n clears every flop.
- Reset values: data_out=0, data_valid=0, health_fail=0, drop_count=0. Internal state also resets: synchroniser=0, divider=0, pair FSM=FIRST, shift register=0, bit count=0, repeat count=0.
- Synchroniser: 2 flops on raw_bit. Only the second flop (sbit) is used downstream.
- Divider:
  - While enable=1, the divider counts 0..SAMPLE_DIV-1 and wraps.
  - The sample strobe is high in the cycle where divider==SAMPLE_DIV-1.
  - While enable=0, the divider is held at 0, no strobes occur, and the pair FSM returns to FIRST.
  - The partial word and bit count are retained while enable=0.
- Pair FSM (states FIRST, SECOND), advancing only on strobe:
  - FIRST: latch sbit into first, go to SECOND.
  - SECOND: compare sbit with first.
    - If they differ, emit the bit "first" (pair 10 emits 1, pair 01 emits 0).
    - If they are equal, emit nothing.
    - Go to FIRST in either case.
- Packing:
  - An emitted bit shifts in at the LSB: shreg <= {shreg[W-2:0], bit}. The first emitted bit ends up as the MSB.
  - bit count increments per emitted bit.
  - On the edge where the WORD_WIDTH-th bit shifts in, the word is complete and bit count returns to 0.
- Word completion:
  - The complete word is loaded into data_out when data_valid=0, or when data_valid and data_ready are both high in the same cycle (simultaneous consume and load is allowed: valid stays 1 with the new word).
  - Otherwise the word is discarded and drop_count increments, saturating at 255.
  - Latency: data_valid rises in the cycle after the strobe that completes the word.
- Output handshake:
  - data_valid stays high and data_out stays stable until a cycle with data_ready=1.
  - data_valid falls after that cycle unless a new word loads on the same edge.
- Health test:
  - On each strobe, the repeat count resets to 1 if sbit differs from the previous sample; otherwise it increments (saturating).
  - When the repeat count reaches REP_LIMIT, health_fail is set. It is sticky until rst_n.
  - While health_fail=1, completed words are neither loaded nor counted as drops. A word already held may still drain.
- Reset mid-operation: any partial word, pending pair bit and held word are lost. After reset, a fresh WORD_WIDTH bits are needed for the next word.

Test Plan:
- Reset check: assert rst_n=0 with arbitrary inputs -> data_valid=0, data_out=0x00, health_fail=0, drop_count=0, all asynchronously.
- Pairs (1,0)x8 with enable=1, data_ready=1, raw_bit held for each full 4-cycle sample period -> one word 0xFF, data_valid high for 1 cycle. Pairs (0,1)x8 -> 0x00.
- Discard and ordering: raw pairs 10,00,01,11, then 10,01 repeated to total 8 emitted bits -> data_out=0xAA. The 00/11 pairs add no bits.
- Backpressure with data_ready=0: generate 2 words (0xF0 then 0x0F) -> data_out=0xF0 held, drop_count=1. Raise data_ready -> 0xF0 accepted, data_valid=0. Also: word completes on the same edge a held word is accepted -> new word appears with no valid gap.
- Health test: raw_bit stuck at 1 for 32 strobes -> health_fail=1 on the 32nd strobe. Further alternating pairs produce no words and drop_count stays unchanged. rst_n pulse clears health_fail.
- Reset mid-word: 5 bits emitted, then rst_n low for 1 cycle, then 8 pairs (1,0) -> exactly one word 0xFF, with no residual bits from before the reset.
